// File: rtl/fp_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_acc_pkg                                                                 |
// | Shared types and helpers for the single-precision dot-product accumulator. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fp_acc_pkg;

  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    OUT   = 3'd4
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MANT_W:0]  mant;
  } fp_op_t;

  // Zero exponent flushes the fraction; a special keeps only its hidden bit.
  function automatic fp_op_t fp_unpack(input logic [31:0] v);
    fp_op_t op;
    op.sign = v[31];
    op.exp  = v[30:23];
    if (op.exp == '0) begin
      op.mant = '0;
    end else if (op.exp == EXP_SPECIAL) begin
      op.mant = {1'b1, {MANT_W{1'b0}}};
    end else begin
      op.mant = {1'b1, v[22:0]};
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc25.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_lzc25                                                                   |
// | Combinational 25-bit leading-zero counter (returns 25 for an all-zero in). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_lzc25 (
  input  logic [24:0] value,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    count = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (value[i]) begin
        count = 5'(24 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_dot_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_dot_accumulator                                                         |
// | Multi-cycle FP32 adder reducing a product stream to one sum per vector.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_dot_accumulator
  import fp_acc_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int SHIFT_SAT = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [EXP_W-1:0] SHIFT_SAT_C = EXP_W'(SHIFT_SAT);

  state_t             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               special_q, special_d;
  logic               special_sign_q, special_sign_d;
  logic [31:0]        x_q, x_d;
  logic               last_q, last_d;
  logic               a_sign_q, a_sign_d;
  logic [EXP_W-1:0]   a_exp_q, a_exp_d;
  logic [24:0]        a_mant_q, a_mant_d;
  logic [24:0]        b_mant_q, b_mant_d;
  logic               sub_q, sub_d;
  logic [25:0]        sum_q, sum_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  fp_op_t             op_acc, op_x, op_a, op_b;
  logic [EXP_W-1:0]   exp_diff;
  logic [24:0]        b_shift;

  logic [4:0]         lzc_count;
  logic [24:0]        norm_shift;
  logic [23:0]        norm_mant;
  logic               norm_guard;
  logic [9:0]         norm_exp;
  logic [24:0]        round_sum;
  logic [9:0]         final_exp;
  logic [22:0]        final_frac;
  logic [31:0]        norm_result;

  // Larger magnitude becomes A so the subtraction never goes negative.
  always_comb begin
    op_acc = fp_unpack(acc_q);
    op_x   = fp_unpack(x_q);
    if ({op_acc.exp, op_acc.mant} >= {op_x.exp, op_x.mant}) begin
      op_a = op_acc;
      op_b = op_x;
    end else begin
      op_a = op_x;
      op_b = op_acc;
    end
    exp_diff = op_a.exp - op_b.exp;
    b_shift  = (exp_diff >= SHIFT_SAT_C) ? 25'd0 : ({op_b.mant, 1'b0} >> exp_diff);
  end

  fp_lzc25 u_lzc (
    .value (sum_q[24:0]),
    .count (lzc_count)
  );

  always_comb begin
    norm_shift = sum_q[24:0] << lzc_count;
    if (sum_q[25]) begin
      norm_mant  = sum_q[25:2];
      norm_guard = sum_q[1];
      norm_exp   = {2'b00, a_exp_q} + 10'd1;
    end else begin
      norm_mant  = norm_shift[24:1];
      norm_guard = norm_shift[0];
      norm_exp   = {2'b00, a_exp_q} - {5'd0, lzc_count};
    end
    round_sum  = {1'b0, norm_mant} + {24'd0, norm_guard};
    final_exp  = norm_exp + {9'd0, round_sum[24]};
    final_frac = round_sum[24] ? round_sum[23:1] : round_sum[22:0];

    if (special_q) begin
      norm_result = {special_sign_q, EXP_SPECIAL, {MANT_W{1'b0}}};
    end else if (sum_q == '0 || final_exp[9] || final_exp == '0) begin
      norm_result = 32'h0000_0000;
    end else if (final_exp >= 10'd255) begin
      norm_result = {a_sign_q, EXP_SPECIAL, {MANT_W{1'b0}}};
    end else begin
      norm_result = {a_sign_q, final_exp[7:0], final_frac};
    end
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    count_d        = count_q;
    special_d      = special_q;
    special_sign_d = special_sign_q;
    x_d            = x_q;
    last_d         = last_q;
    a_sign_d       = a_sign_q;
    a_exp_d        = a_exp_q;
    a_mant_d       = a_mant_q;
    b_mant_d       = b_mant_q;
    sub_d          = sub_q;
    sum_d          = sum_q;
    out_valid_d    = out_valid_q;
    out_sum_d      = out_sum_q;
    out_count_d    = out_count_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d     = in_data;
          last_d  = in_last;
          count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
          if (in_data[30:23] == EXP_SPECIAL && !special_q) begin
            special_d      = 1'b1;
            special_sign_d = in_data[31];
          end
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        a_sign_d = op_a.sign;
        a_exp_d  = op_a.exp;
        a_mant_d = {op_a.mant, 1'b0};
        b_mant_d = b_shift;
        sub_d    = op_a.sign ^ op_b.sign;
        state_d  = ADD;
      end
      ADD: begin
        sum_d   = sub_q ? ({1'b0, a_mant_q} - {1'b0, b_mant_q})
                        : ({1'b0, a_mant_q} + {1'b0, b_mant_q});
        state_d = NORM;
      end
      NORM: begin
        acc_d = norm_result;
        if (last_q) begin
          out_valid_d = 1'b1;
          out_sum_d   = norm_result;
          out_count_d = count_q;
          state_d     = OUT;
        end else begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d    = 1'b0;
          acc_d          = 32'h0000_0000;
          count_d        = '0;
          special_d      = 1'b0;
          special_sign_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      count_q        <= '0;
      special_q      <= 1'b0;
      special_sign_q <= 1'b0;
      x_q            <= '0;
      last_q         <= 1'b0;
      a_sign_q       <= 1'b0;
      a_exp_q        <= '0;
      a_mant_q       <= '0;
      b_mant_q       <= '0;
      sub_q          <= 1'b0;
      sum_q          <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      count_q        <= count_d;
      special_q      <= special_d;
      special_sign_q <= special_sign_d;
      x_q            <= x_d;
      last_q         <= last_d;
      a_sign_q       <= a_sign_d;
      a_exp_q        <= a_exp_d;
      a_mant_q       <= a_mant_d;
      b_mant_q       <= b_mant_d;
      sub_q          <= sub_d;
      sum_q          <= sum_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_sum_q      <= out_sum_d;
      out_count_q    <= out_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule
`default_nettype wire
